spiflash_rom_if: RTL and testbench

- Slave on the CPU native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Replaces the BRAM image behind the flash window 0x1xxx_xxxx by fetching 32-bit words from an external SPI NOR flash.
- Uses the READ command (0x03) in SPI mode 0.
- The top-level address decode gates mem_valid. The block returns mem_ready/mem_rdata into the CPU read mux.

---
 rtl/spiflash_rom_if.sv | 162 ++++++++++++++++
 tb/tb_spiflash_rom_if.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spiflash_rom_if.sv
// Memory-bus slave that fetches 32-bit words from SPI NOR flash (READ 0x03, mode 0).
// Define SPIFLASH_SEQ_EN to keep CS low between reads and stream sequential words.
module spiflash_rom_if #(
  parameter int          CLK_DIV      = 2,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int          CS_GAP       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [23:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        flash_csn,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
`ifdef SPIFLASH_SEQ_EN
  localparam logic [2:0] S_HOLD  = 3'd5;
`endif

  localparam logic [7:0]  HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP * CLK_DIV - 1);

  logic [2:0]  state;
  logic [63:0] sreg;
  logic [31:0] rsh;
  logic [7:0]  hcnt;
  logic [5:0]  bcnt;
  logic [15:0] gcnt;
  logic [23:0] fa;
  logic        unused_addr_lsb;
`ifdef SPIFLASH_SEQ_EN
  logic [23:0] last_fa;
  logic        is_rd;
`endif

  assign unused_addr_lsb = ^mem_addr[1:0];
  assign fa              = {mem_addr[23:2], 2'b00} + FLASH_OFFSET;
  assign flash_mosi      = sreg[63];
  // Bytes arrive first-to-last in rsh[31:24]..rsh[7:0]; first byte is the LSB of the word.
  assign mem_rdata = mem_ready ? {rsh[7:0], rsh[15:8], rsh[23:16], rsh[31:24]} : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      rsh       <= '0;
      hcnt      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      flash_csn <= 1'b1;
      flash_clk <= 1'b0;
      mem_ready <= 1'b0;
`ifdef SPIFLASH_SEQ_EN
      last_fa   <= '0;
      is_rd     <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;
      case (state)
        S_IDLE: if (mem_valid) begin
          rsh <= '0;
          if (|mem_wstrb) begin
            state     <= S_DONE;
            mem_ready <= 1'b1;
`ifdef SPIFLASH_SEQ_EN
            is_rd     <= 1'b0;
`endif
          end else begin
            sreg      <= {8'h03, fa, 32'h0};
            flash_csn <= 1'b0;
            hcnt      <= '0;
            state     <= S_SETUP;
`ifdef SPIFLASH_SEQ_EN
            last_fa   <= fa;
            is_rd     <= 1'b1;
`endif
          end
        end
        S_SETUP: begin
          if (hcnt == HALF_LAST) begin
            hcnt  <= '0;
            bcnt  <= 6'd63;
            state <= S_SHIFT;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        S_SHIFT: begin
          // Sample in the first cycle of the SCK high half.
          if (flash_clk && hcnt == 8'd0)
            rsh <= {rsh[30:0], flash_miso};
          if (hcnt == HALF_LAST) begin
            hcnt <= '0;
            if (flash_clk) begin
              flash_clk <= 1'b0;
              if (bcnt == 6'd0) begin
                state     <= S_DONE;
                mem_ready <= 1'b1;
`ifndef SPIFLASH_SEQ_EN
                flash_csn <= 1'b1;
`endif
              end else begin
                bcnt <= bcnt - 6'd1;
                sreg <= {sreg[62:0], 1'b0};
              end
            end else begin
              flash_clk <= 1'b1;
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        S_DONE: begin
`ifdef SPIFLASH_SEQ_EN
          if (is_rd) begin
            state <= S_HOLD;
          end else begin
            gcnt  <= GAP_LAST;
            state <= S_GAP;
          end
`else
          gcnt  <= GAP_LAST;
          state <= S_GAP;
`endif
        end
        S_GAP: begin
          if (gcnt == 16'd0) state <= S_IDLE;
          else gcnt <= gcnt - 16'd1;
        end
`ifdef SPIFLASH_SEQ_EN
        S_HOLD: if (mem_valid) begin
          if (mem_wstrb == 4'h0 && fa == last_fa + 24'd4) begin
            // Flash is still streaming: clock out just the next data word.
            rsh     <= '0;
            sreg    <= '0;
            bcnt    <= 6'd31;
            hcnt    <= '0;
            last_fa <= fa;
            state   <= S_SHIFT;
          end else begin
            flash_csn <= 1'b1;
            gcnt      <= GAP_LAST;
            state     <= S_GAP;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_rom_if.sv
// Directed bench for spiflash_rom_if with a behavioural SPI NOR flash model.
module tb_spiflash_rom_if;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [23:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        flash_csn, flash_clk, flash_mosi;
  logic        flash_miso = 1'b0;

  int checks = 0;
  int failures = 0;

  spiflash_rom_if #(.CLK_DIV(2), .FLASH_OFFSET(24'h100000), .CS_GAP(2)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .flash_csn(flash_csn), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [7:0] t;
    case (a)
      24'h100000: t = 8'h13;
      24'h100001: t = 8'h05;
      24'h100002, 24'h100003: t = 8'h00;
      default: t = a[7:0] * 8'd29 + a[15:8] + 8'h3C;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Flash model: 32 command/address bits in on rising SCK, data out on falling SCK.
  int unsigned fbits = 0;
  logic [31:0] fcmd = '0;
  always @(posedge flash_clk or posedge flash_csn) begin
    if (flash_csn) fbits = 0;
    else begin
      if (fbits < 32) fcmd = {fcmd[30:0], flash_mosi};
      fbits = fbits + 1;
    end
  end
  always @(negedge flash_clk) begin
    int k;
    logic [7:0] b;
    if (!flash_csn && fbits >= 32) begin
      k = int'(fbits) - 32;
      b = fbyte(fcmd[23:0] + 24'(k / 8));
      flash_miso = b[7 - (k % 8)];
    end
  end

  int sck_edges = 0, rdy_pulses = 0, csn_falls = 0;
  always @(posedge flash_clk) sck_edges++;
  always @(negedge flash_csn) csn_falls++;
  always @(negedge clk) if (mem_ready) rdy_pulses++;

  task automatic apply_reset();
    reset = 1'b1;
    mem_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic do_xfer(input logic [23:0] a, input logic [3:0] ws, input bit drop,
                         input bit hold, output logic [31:0] d, output int lat);
    @(negedge clk);
    mem_addr = a; mem_wstrb = ws; mem_valid = 1'b1;
    lat = 0; d = '0;
    while (lat < 5000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (drop) mem_valid = 1'b0;
      if (mem_ready) begin
        d = mem_rdata;
        break;
      end
    end
    if (!hold) mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    int e0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (flash_csn !== 1'b1) begin failures++; $display("FAIL reset_csn got=%b exp=1", flash_csn); end
    checks++; if (flash_clk !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", flash_clk); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    reset = 1'b0;
    e0 = sck_edges;
    repeat (20) @(negedge clk);
    checks++; if (sck_edges !== e0 || flash_csn !== 1'b1) begin
      failures++; $display("FAIL idle_quiet sck_edges=%0d exp=%0d csn=%b", sck_edges, e0, flash_csn);
    end
  endtask

  task automatic test_single_read();
    logic [31:0] d; int lat, p0; bit csn_ok;
    apply_reset();
    p0 = rdy_pulses;
    do_xfer(24'h0, 4'h0, 1'b0, 1'b0, d, lat);
    checks++; if (lat !== 259) begin failures++; $display("FAIL read_latency got=%0d exp=259", lat); end
    checks++; if (d !== 32'h00000513) begin failures++; $display("FAIL read_data got=%h exp=00000513", d); end
    checks++; if (fcmd !== 32'h03100000) begin failures++; $display("FAIL read_cmd_addr got=%h exp=03100000", fcmd); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL ready_one_cycle got=%b exp=0", mem_ready); end
    csn_ok = 1'b1;
`ifndef SPIFLASH_SEQ_EN
    repeat (4) begin if (flash_csn !== 1'b1) csn_ok = 1'b0; @(negedge clk); end
    checks++; if (!csn_ok) begin failures++; $display("FAIL csn_gap got=low exp=high for 4 cycles"); end
`else
    repeat (4) begin if (flash_csn !== 1'b0) csn_ok = 1'b0; @(negedge clk); end
    checks++; if (!csn_ok) begin failures++; $display("FAIL hold_csn got=high exp=low in hold"); end
`endif
    checks++; if (rdy_pulses !== p0 + 1) begin failures++; $display("FAIL read_pulses got=%0d exp=%0d", rdy_pulses, p0 + 1); end
  endtask

  task automatic test_write();
    logic [31:0] d; int lat, f0;
    apply_reset();
    f0 = csn_falls;
    do_xfer(24'h40, 4'hF, 1'b0, 1'b0, d, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL write_latency got=%0d exp=1", lat); end
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL write_rdata got=%h exp=0", d); end
    repeat (5) @(negedge clk);
    checks++; if (csn_falls !== f0) begin failures++; $display("FAIL write_csn got=%0d falls exp=%0d", csn_falls, f0); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] d; int lat, p0, n;
    apply_reset();
    p0 = rdy_pulses;
    @(negedge clk);
    mem_addr = 24'h0; mem_wstrb = 4'h0; mem_valid = 1'b1;
    n = 0;
    while (fbits < 40 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin failures++; $display("FAIL reach_bit40 got=timeout exp=bit 40"); end
    reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (flash_csn !== 1'b1 || flash_clk !== 1'b0 || mem_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset csn=%b sck=%b ready=%b exp=1/0/0", flash_csn, flash_clk, mem_ready);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rdy_pulses !== p0) begin failures++; $display("FAIL mid_reset_pulse got=%0d exp=%0d", rdy_pulses, p0); end
    do_xfer(24'h4, 4'h0, 1'b1, 1'b0, d, lat);
    checks++; if (d !== fword(24'h100004)) begin failures++; $display("FAIL read4_data got=%h exp=%h", d, fword(24'h100004)); end
    checks++; if (lat !== 259) begin failures++; $display("FAIL read4_latency got=%0d exp=259", lat); end
    checks++; if (fcmd !== 32'h03100004) begin failures++; $display("FAIL read4_cmd got=%h exp=03100004", fcmd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1; int lat, f0;
    apply_reset();
    f0 = csn_falls;
    do_xfer(24'h0, 4'h0, 1'b0, 1'b1, d0, lat);
    do_xfer(24'h8, 4'h0, 1'b0, 1'b0, d1, lat);
    checks++; if (d0 !== 32'h00000513) begin failures++; $display("FAIL b2b_first got=%h exp=00000513", d0); end
    checks++; if (d1 !== fword(24'h100008)) begin failures++; $display("FAIL b2b_second got=%h exp=%h", d1, fword(24'h100008)); end
    checks++; if (csn_falls !== f0 + 2) begin failures++; $display("FAIL b2b_windows got=%0d exp=%0d", csn_falls - f0, 2); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int lat;
    apply_reset();
    do_xfer(24'hFFFFFC, 4'h0, 1'b0, 1'b0, d, lat);
    checks++; if (fcmd !== 32'h030FFFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=030FFFFC", fcmd); end
    checks++; if (d !== fword(24'h0FFFFC)) begin failures++; $display("FAIL wrap_data got=%h exp=%h", d, fword(24'h0FFFFC)); end
  endtask

`ifdef SPIFLASH_SEQ_EN
  task automatic test_seq();
    logic [31:0] d; int lat, f0;
    apply_reset();
    do_xfer(24'h0, 4'h0, 1'b0, 1'b0, d, lat);
    f0 = csn_falls;
    do_xfer(24'h4, 4'h0, 1'b0, 1'b0, d, lat);
    checks++; if (lat !== 129) begin failures++; $display("FAIL seq_latency got=%0d exp=129", lat); end
    checks++; if (d !== fword(24'h100004)) begin failures++; $display("FAIL seq_data got=%h exp=%h", d, fword(24'h100004)); end
    checks++; if (csn_falls !== f0) begin failures++; $display("FAIL seq_no_cmd got=%0d exp=%0d", csn_falls, f0); end
    do_xfer(24'h20, 4'h0, 1'b0, 1'b0, d, lat);
    checks++; if (lat !== 264) begin failures++; $display("FAIL break_latency got=%0d exp=264", lat); end
    checks++; if (csn_falls !== f0 + 1) begin failures++; $display("FAIL break_csn got=%0d exp=%0d", csn_falls, f0 + 1); end
    checks++; if (fcmd !== 32'h03100020) begin failures++; $display("FAIL break_cmd got=%h exp=03100020", fcmd); end
    checks++; if (d !== fword(24'h100020)) begin failures++; $display("FAIL break_data got=%h exp=%h", d, fword(24'h100020)); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (flash_csn !== 1'b1) begin failures++; $display("FAIL hold_reset_csn got=%b exp=1", flash_csn); end
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_reset_mid_shift();
    test_back_to_back();
    test_wrap();
`ifdef SPIFLASH_SEQ_EN
    test_seq();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
